led_ram_sched: RTL and testbench

LED_RAM_SCHED -- requirements
Module: led_ram_sched

---
 rtl/led_ram_sched.sv | 157 +++++++++++++++
 tb/tb_led_ram_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_ram_sched.sv
// led_ram_sched: shares the single LED RAM write port between the light pen,
// the game/host and a 64-cell clear sweep. Writes are issued one cycle after
// the request is seen, with matching one-cycle ack pulses. A clear overrides
// both requesters until it completes.
// Optional feature: define LED_CLR_ON_STATE_EN to also start a clear whenever
// the system state input changes.
module led_ram_sched #(
  parameter logic [3:0] CLR_VALUE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state,
  input  logic       clr_start,
  input  logic       pen_req,
  input  logic [2:0] pen_row,
  input  logic [2:0] pen_col,
  input  logic [3:0] pen_data,
  output logic       pen_ack,
  input  logic       host_req,
  input  logic [2:0] host_row,
  input  logic [2:0] host_col,
  input  logic [3:0] host_data,
  output logic       host_ack,
  output logic       ram_we,
  output logic [5:0] ram_addr,
  output logic [3:0] ram_wdata,
  output logic       busy
);

  typedef enum logic {IDLE, CLEAR} fsm_t;

  fsm_t       fsm_q, fsm_d;
  logic       ram_we_q, ram_we_d;
  logic [5:0] ram_addr_q, ram_addr_d;
  logic [3:0] ram_wdata_q, ram_wdata_d;
  logic       pen_ack_q, pen_ack_d;
  logic       host_ack_q, host_ack_d;
  logic       busy_q, busy_d;
  logic       rr_q, rr_d;
  logic [6:0] sweep_cnt_q, sweep_cnt_d;

  logic clr_trig;
  logic pen_elig;
  logic host_elig;
  logic grant_pen;
  logic grant_host;

`ifdef LED_CLR_ON_STATE_EN
  logic [3:0] state_dly_q, state_dly_d;
  logic       state_vld_q, state_vld_d;

  assign state_dly_d = state;
  assign state_vld_d = 1'b1;

  // Delayed copy of the system state; the valid flag masks the first cycle
  // after reset so loading the copy never looks like a state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_dly_q <= 4'd0;
      state_vld_q <= 1'b0;
    end else begin
      state_dly_q <= state_dly_d;
      state_vld_q <= state_vld_d;
    end
  end

  assign clr_trig = clr_start | (state_vld_q & (state != state_dly_q));
`else
  logic unused_state;
  assign unused_state = ^state;
  assign clr_trig     = clr_start;
`endif

  // A requester whose ack is currently high is treated as already served, so
  // a request dropped one cycle late cannot cause a second write.
  assign pen_elig   = pen_req & ~pen_ack_q;
  assign host_elig  = host_req & ~host_ack_q;
  assign grant_pen  = pen_elig & (~host_elig | ~rr_q);
  assign grant_host = host_elig & (~pen_elig | rr_q);

  // Next-state logic: clear trigger beats sweep progress beats requests.
  always_comb begin
    fsm_d       = fsm_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    pen_ack_d   = 1'b0;
    host_ack_d  = 1'b0;
    busy_d      = busy_q;
    rr_d        = rr_q;
    sweep_cnt_d = sweep_cnt_q;
    if (clr_trig) begin
      fsm_d       = CLEAR;
      ram_we_d    = 1'b1;
      ram_addr_d  = 6'd0;
      ram_wdata_d = CLR_VALUE;
      busy_d      = 1'b1;
      sweep_cnt_d = 7'd1;
    end else if (fsm_q == CLEAR) begin
      if (sweep_cnt_q == 7'd64) begin
        fsm_d       = IDLE;
        busy_d      = 1'b0;
        sweep_cnt_d = 7'd0;
      end else begin
        ram_we_d    = 1'b1;
        ram_addr_d  = sweep_cnt_q[5:0];
        ram_wdata_d = CLR_VALUE;
        sweep_cnt_d = sweep_cnt_q + 7'd1;
      end
    end else if (grant_pen) begin
      ram_we_d    = 1'b1;
      ram_addr_d  = {pen_row, pen_col};
      ram_wdata_d = pen_data;
      pen_ack_d   = 1'b1;
      rr_d        = 1'b1;
    end else if (grant_host) begin
      ram_we_d    = 1'b1;
      ram_addr_d  = {host_row, host_col};
      ram_wdata_d = host_data;
      host_ack_d  = 1'b1;
      rr_d        = 1'b0;
    end
  end

  // FSM and registered outputs; reset aborts any sweep immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= 6'd0;
      ram_wdata_q <= 4'd0;
      pen_ack_q   <= 1'b0;
      host_ack_q  <= 1'b0;
      busy_q      <= 1'b0;
      rr_q        <= 1'b0;
      sweep_cnt_q <= 7'd0;
    end else begin
      fsm_q       <= fsm_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      pen_ack_q   <= pen_ack_d;
      host_ack_q  <= host_ack_d;
      busy_q      <= busy_d;
      rr_q        <= rr_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign pen_ack   = pen_ack_q;
  assign host_ack  = host_ack_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_led_ram_sched.sv
// Testbench for led_ram_sched: a cycle table for single/tied requests, then
// hand-written sequences for round-robin, clear sweeps, restart, state-change
// clears and reset mid-sweep. Every observed write is matched against a queue
// of expected writes.
module tb_led_ram_sched;

  localparam logic [3:0] CLR_V = 4'h6;

  logic       clk;
  logic       rst_n;
  logic [3:0] state;
  logic       clr_start;
  logic       pen_req;
  logic [2:0] pen_row;
  logic [2:0] pen_col;
  logic [3:0] pen_data;
  logic       pen_ack;
  logic       host_req;
  logic [2:0] host_row;
  logic [2:0] host_col;
  logic [3:0] host_data;
  logic       host_ack;
  logic       ram_we;
  logic [5:0] ram_addr;
  logic [3:0] ram_wdata;
  logic       busy;

  typedef struct packed {
    logic       pa;
    logic       ha;
    logic       bz;
    logic [5:0] addr;
    logic [3:0] data;
  } wr_t;

  typedef struct packed {
    logic       pr;
    logic [2:0] prow;
    logic [2:0] pcol;
    logic [3:0] pdat;
    logic       hr;
    logic [2:0] hrow;
    logic [2:0] hcol;
    logic [3:0] hdat;
    logic       e_we;
    logic       e_pa;
    logic       e_ha;
    logic [5:0] e_addr;
    logic [3:0] e_data;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[11];
  int   tests;
  int   failures;

  led_ram_sched #(.CLR_VALUE(CLR_V)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .clr_start(clr_start),
    .pen_req(pen_req), .pen_row(pen_row), .pen_col(pen_col), .pen_data(pen_data),
    .pen_ack(pen_ack),
    .host_req(host_req), .host_row(host_row), .host_col(host_col), .host_data(host_data),
    .host_ack(host_ack),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  // One clock; any write seen is popped from the expected queue and compared.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (ram_we) begin
      if (exp_q.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=%0h, required no write", ram_addr, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_write", {19'd0, pen_ack, host_ack, busy, ram_addr, ram_wdata},
                    {19'd0, e.pa, e.ha, e.bz, e.addr, e.data});
      end
    end
  endtask

  task automatic pushReq(input logic is_pen, input logic [5:0] addr, input logic [3:0] data);
    exp_q.push_back('{pa: is_pen, ha: ~is_pen, bz: 1'b0, addr: addr, data: data});
  endtask

  task automatic pushClear(input int count);
    for (int i = 0; i < count; i++)
      exp_q.push_back('{pa: 1'b0, ha: 1'b0, bz: 1'b1, addr: i[5:0], data: CLR_V});
  endtask

  task automatic applyStimulus(input vec_t v);
    pen_req   = v.pr;
    pen_row   = v.prow;
    pen_col   = v.pcol;
    pen_data  = v.pdat;
    host_req  = v.hr;
    host_row  = v.hrow;
    host_col  = v.hcol;
    host_data = v.hdat;
  endtask

  task automatic doReset(input logic [3:0] st);
    rst_n     = 1'b0;
    state     = st;
    clr_start = 1'b0;
    pen_req   = 1'b0;
    host_req  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b0,3'd0,3'd0,4'h0, 1'b0,3'd0,3'd0,4'h0, 1'b0,1'b0,1'b0, 6'd0,  4'h0};
    vecs[1]  = '{1'b1,3'd3,3'd5,4'hA, 1'b0,3'd0,3'd0,4'h0, 1'b1,1'b1,1'b0, 6'd29, 4'hA};
    vecs[2]  = '{1'b1,3'd3,3'd5,4'hA, 1'b0,3'd0,3'd0,4'h0, 1'b0,1'b0,1'b0, 6'd29, 4'hA};
    vecs[3]  = '{1'b0,3'd0,3'd0,4'h0, 1'b0,3'd0,3'd0,4'h0, 1'b0,1'b0,1'b0, 6'd29, 4'hA};
    vecs[4]  = '{1'b0,3'd0,3'd0,4'h0, 1'b1,3'd7,3'd7,4'hF, 1'b1,1'b0,1'b1, 6'd63, 4'hF};
    vecs[5]  = '{1'b1,3'd0,3'd1,4'h1, 1'b1,3'd2,3'd3,4'h2, 1'b1,1'b1,1'b0, 6'd1,  4'h1};
    vecs[6]  = '{1'b1,3'd0,3'd1,4'h1, 1'b1,3'd2,3'd3,4'h2, 1'b1,1'b0,1'b1, 6'd19, 4'h2};
    vecs[7]  = '{1'b0,3'd0,3'd0,4'h0, 1'b1,3'd2,3'd3,4'h2, 1'b0,1'b0,1'b0, 6'd19, 4'h2};
    vecs[8]  = '{1'b1,3'd4,3'd0,4'h3, 1'b1,3'd5,3'd1,4'h4, 1'b1,1'b1,1'b0, 6'd32, 4'h3};
    vecs[9]  = '{1'b0,3'd0,3'd0,4'h0, 1'b1,3'd5,3'd1,4'h4, 1'b1,1'b0,1'b1, 6'd41, 4'h4};
    vecs[10] = '{1'b0,3'd0,3'd0,4'h0, 1'b0,3'd0,3'd0,4'h0, 1'b0,1'b0,1'b0, 6'd41, 4'h4};

    tests = 0;
    failures = 0;
    pen_row = 3'd0; pen_col = 3'd0; pen_data = 4'd0;
    host_row = 3'd0; host_col = 3'd0; host_data = 4'd0;

    // Reset values
    doReset(4'd0);
    checkOutput("reset_outputs", {26'd0, ram_we, pen_ack, host_ack, busy, ram_addr[0], ram_wdata[0]}, 32'd0);
    checkOutput("reset_addr", {26'd0, ram_addr}, 32'd0);
    checkOutput("reset_data", {28'd0, ram_wdata}, 32'd0);

    // Cycle table: single, held-too-long and tied requests
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      if (vecs[i].e_we)
        pushReq(vecs[i].e_pa, vecs[i].e_addr, vecs[i].e_data);
      tick();
      checkOutput($sformatf("vec%0d_we", i), {31'd0, ram_we}, {31'd0, vecs[i].e_we});
      checkOutput($sformatf("vec%0d_acks", i), {30'd0, pen_ack, host_ack}, {30'd0, vecs[i].e_pa, vecs[i].e_ha});
      checkOutput($sformatf("vec%0d_addr", i), {26'd0, ram_addr}, {26'd0, vecs[i].e_addr});
      checkOutput($sformatf("vec%0d_data", i), {28'd0, ram_wdata}, {28'd0, vecs[i].e_data});
    end
    checkOutput("table_drain", exp_q.size(), 32'd0);

    // Both requests held four cycles after reset: pen, host, pen, host
    doReset(4'd0);
    pen_req = 1'b1;  pen_row = 3'd1;  pen_col = 3'd2;  pen_data = 4'h3;
    host_req = 1'b1; host_row = 3'd6; host_col = 3'd6; host_data = 4'h9;
    pushReq(1'b1, 6'd10, 4'h3);
    pushReq(1'b0, 6'd54, 4'h9);
    pushReq(1'b1, 6'd10, 4'h3);
    pushReq(1'b0, 6'd54, 4'h9);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("rr_we%0d", i), {31'd0, ram_we}, 32'd1);
    end
    pen_req = 1'b0;
    host_req = 1'b0;
    tick();
    checkOutput("rr_idle_we", {31'd0, ram_we}, 32'd0);
    checkOutput("rr_drain", exp_q.size(), 32'd0);

    // Clear sweep with a host request raised mid-sweep
    clr_start = 1'b1;
    pushClear(64);
    tick();
    clr_start = 1'b0;
    checkOutput("clr_busy0", {31'd0, busy}, 32'd1);
    for (int i = 1; i < 64; i++) begin
      if (i == 10) begin
        host_req = 1'b1; host_row = 3'd2; host_col = 3'd2; host_data = 4'h7;
        pushReq(1'b0, 6'd18, 4'h7);
      end
      tick();
      checkOutput($sformatf("clr_busy%0d", i), {30'd0, busy, ram_we}, 32'd3);
    end
    tick();
    checkOutput("clr_end", {29'd0, busy, ram_we, host_ack}, 32'd0);
    tick();
    checkOutput("clr_host_ack", {31'd0, host_ack}, 32'd1);
    host_req = 1'b0;
    tick();
    checkOutput("clr_drain", exp_q.size(), 32'd0);

    // Clear coinciding with a pen request, restarted at address 40
    clr_start = 1'b1;
    pen_req = 1'b1; pen_row = 3'd1; pen_col = 3'd1; pen_data = 4'h5;
    pushClear(41);
    tick();
    clr_start = 1'b0;
    checkOutput("clr_prio_ack", {31'd0, pen_ack}, 32'd0);
    for (int i = 1; i <= 40; i++) tick();
    checkOutput("restart_at40", {26'd0, ram_addr}, 32'd40);
    clr_start = 1'b1;
    pushClear(64);
    pushReq(1'b1, 6'd9, 4'h5);
    tick();
    clr_start = 1'b0;
    checkOutput("restart_addr0", {25'd0, busy, ram_addr}, {25'd0, 1'b1, 6'd0});
    for (int i = 1; i < 64; i++) begin
      tick();
      checkOutput($sformatf("restart_busy%0d", i), {31'd0, busy}, 32'd1);
    end
    tick();
    checkOutput("restart_end", {30'd0, busy, ram_we}, 32'd0);
    tick();
    checkOutput("restart_pen_ack", {31'd0, pen_ack}, 32'd1);
    pen_req = 1'b0;
    tick();
    checkOutput("restart_drain", exp_q.size(), 32'd0);

    // State change 1 -> 2
    doReset(4'd1);
    tick();
    tick();
    checkOutput("state_no_auto_clear", {30'd0, busy, ram_we}, 32'd0);
    state = 4'd2;
`ifdef LED_CLR_ON_STATE_EN
    pushClear(64);
    tick();
    checkOutput("state_clr_start", {30'd0, busy, ram_we}, 32'd3);
    for (int i = 1; i < 64; i++) tick();
    tick();
    checkOutput("state_clr_end", {31'd0, busy}, 32'd0);
`else
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("state_no_write%0d", i), {30'd0, busy, ram_we}, 32'd0);
    end
`endif
    checkOutput("state_drain", exp_q.size(), 32'd0);

    // Reset asserted at sweep address 20
    clr_start = 1'b1;
    pushClear(21);
    tick();
    clr_start = 1'b0;
    for (int i = 1; i <= 20; i++) tick();
    checkOutput("abort_at20", {26'd0, ram_addr}, 32'd20);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_async", {24'd0, ram_we, busy, ram_addr}, 32'd0);
    state = 4'd5;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 70; i++) tick();
    checkOutput("abort_no_clear", {30'd0, busy, ram_we}, 32'd0);
    checkOutput("abort_drain", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
